// File: rtl/macro_array_seq.sv
// Phase sequencer and signed accumulator for MACRO_NUM compute-in-memory macros.
// Optional per-element output clamp and sat_flag port: define MACRO_ARRAY_SEQ_SAT_EN.
module macro_array_seq #(
  parameter int FM_DEPTH   = 64,
  parameter int CORE_SIZE  = 9,
  parameter int MACRO_NUM  = 4,
  parameter int MACRO_ROWS = 32,
  parameter int MACRO_COLS = 64,
  parameter int PHASES     = 4,
  parameter int EN_CYC     = 2,
  parameter int ADC_CYC    = 1,
  parameter int OUT_W      = 4 + $clog2((FM_DEPTH / MACRO_ROWS) * PHASES)
`ifdef MACRO_ARRAY_SEQ_SAT_EN
  ,
  parameter int SAT_W      = 6
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [FM_DEPTH-1:0][CORE_SIZE-1:0] data_in,
  output logic m_enable,
  output logic m_adc,
  output logic [1:0] m_chs_ps,
  output logic [MACRO_NUM-1:0][MACRO_ROWS-1:0][CORE_SIZE-1:0] m_din,
  input  logic [MACRO_NUM-1:0][MACRO_COLS-1:0][3:0] m_dout,
  output logic out_valid,
  input  logic out_ready,
  output logic [MACRO_NUM/(FM_DEPTH/MACRO_ROWS)-1:0][MACRO_COLS-1:0][OUT_W-1:0] sum_out,
  output logic busy
`ifdef MACRO_ARRAY_SEQ_SAT_EN
  ,
  output logic sat_flag
`endif
);

  localparam int GROUPS  = FM_DEPTH / MACRO_ROWS;
  localparam int SETS    = MACRO_NUM / GROUPS;
  localparam int CNT_MAX = (EN_CYC > ADC_CYC) ? EN_CYC : ADC_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] ADC_LAST = CNT_W'(ADC_CYC - 1);
  localparam logic [1:0]       PH_LAST  = 2'(PHASES - 1);

  if (FM_DEPTH % MACRO_ROWS != 0) begin : g_bad_depth
    $error("FM_DEPTH must be a multiple of MACRO_ROWS");
  end
  if (MACRO_NUM % GROUPS != 0) begin : g_bad_num
    $error("MACRO_NUM must be a multiple of FM_DEPTH/MACRO_ROWS");
  end
  if (PHASES < 1 || PHASES > 4) begin : g_bad_phases
    $error("PHASES must be within 1..4");
  end
`ifdef MACRO_ARRAY_SEQ_SAT_EN
  if (SAT_W < 1 || SAT_W > OUT_W) begin : g_bad_sat
    $error("SAT_W must be within 1..OUT_W");
  end
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SAMPLE, S_DONE} state_t;

  state_t state_q, state_d;
  logic   ready_q;
  logic [FM_DEPTH-1:0][CORE_SIZE-1:0]       window_q;
  logic [SETS-1:0][MACRO_COLS-1:0][OUT_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] col_sum;
  logic [1:0]       phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic en_done, adc_done;

  assign en_done  = (cnt_q == EN_LAST);
  assign adc_done = (cnt_q == ADC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid && ready_q) state_d = S_CONV;
      S_CONV:   if (en_done) state_d = S_SAMPLE;
      S_SAMPLE: if (adc_done) state_d = (phase_q == PH_LAST) ? S_DONE : S_CONV;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    m_enable  = 1'b0;
    m_adc     = 1'b0;
    m_chs_ps  = '0;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:   in_ready = ready_q;
      S_CONV: begin
        m_enable = 1'b1;
        m_chs_ps = phase_q;
      end
      S_SAMPLE: begin
        m_enable = 1'b1;
        m_adc    = 1'b1;
        m_chs_ps = phase_q;
      end
      S_DONE:   out_valid = 1'b1;
      default:  ;
    endcase
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      acc_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && ready_q) begin
            window_q <= data_in;
            acc_q    <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
          end
        end
        S_CONV: cnt_q <= en_done ? '0 : cnt_q + CNT_W'(1);
        S_SAMPLE: begin
          if (adc_done) begin
            cnt_q <= '0;
            acc_q <= acc_d;
            if (phase_q != PH_LAST) phase_q <= phase_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: if (out_ready) phase_q <= '0;
        default: ;
      endcase
    end
  end

  // Macros s*GROUPS .. s*GROUPS+GROUPS-1 cover the row-groups of output set s.
  always_comb begin
    acc_d   = acc_q;
    col_sum = '0;
    for (int unsigned s = 0; s < SETS; s++) begin
      for (int unsigned c = 0; c < MACRO_COLS; c++) begin
        col_sum = acc_q[s][c];
        for (int unsigned g = 0; g < GROUPS; g++) begin
          col_sum = col_sum + OUT_W'($signed(m_dout[s*GROUPS+g][c]));
        end
        acc_d[s][c] = col_sum;
      end
    end
  end

  always_comb begin
    m_din = '0;
    for (int unsigned m = 0; m < MACRO_NUM; m++) begin
      m_din[m] = window_q[(m % GROUPS)*MACRO_ROWS +: MACRO_ROWS];
    end
  end

`ifdef MACRO_ARRAY_SEQ_SAT_EN
  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(-(1 << (SAT_W - 1)));
  logic signed [OUT_W-1:0] elem;

  always_comb begin
    sum_out  = '0;
    sat_flag = 1'b0;
    elem     = '0;
    if (state_q == S_DONE) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned c = 0; c < MACRO_COLS; c++) begin
          elem = acc_q[s][c];
          if (elem > SAT_MAX) begin
            sum_out[s][c] = SAT_MAX;
            sat_flag      = 1'b1;
          end else if (elem < SAT_MIN) begin
            sum_out[s][c] = SAT_MIN;
            sat_flag      = 1'b1;
          end else begin
            sum_out[s][c] = elem;
          end
        end
      end
    end
  end
`else
  always_comb begin
    sum_out = (state_q == S_DONE) ? acc_q : '0;
  end
`endif

endmodule

// File: doc/macro_array_seq.md
Name: macro_array_seq

Overview:
- Parametrised successor to the fixed four-macro, layer-3 CIM wrapper.
- Drives MACRO_NUM compute-in-memory macros from a FM_DEPTH x CORE_SIZE binary window.
- Sequences the enable/adc/chs_ps phases over time, then captures and accumulates the signed 4-bit macro outputs across phases and across the row-groups that share an output channel set.
- Sits between the layer's window buffer (valid/ready in) and the BN/activation stage (valid/ready out). Macros remain external black boxes.

Parameters:
- FM_DEPTH, 64: input channels; multiple of MACRO_ROWS.
- CORE_SIZE, 9: kernel taps per channel.
- MACRO_NUM, 4: macros driven; multiple of GROUPS = FM_DEPTH/MACRO_ROWS.
- MACRO_ROWS, 32: input channels per macro.
- MACRO_COLS, 64: output columns per macro.
- PHASES, 4: chs_ps phases per window, 1..4.
- EN_CYC, 2: cycles enable is held before ADC.
- ADC_CYC, 1: cycles adc is held high; the capture happens on the last one.
- OUT_W, 4+clog2(GROUPS*PHASES): accumulator/output width, signed.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: window valid.
- in_ready, output, 1: window accepted when in_valid && in_ready.
- data_in, input, [FM_DEPTH][CORE_SIZE]: binary activation window.
- m_enable, output, 1: macro enable, common to all macros.
- m_adc, output, 1: macro ADC strobe, common to all macros.
- m_chs_ps, output, 2: current phase select.
- m_din, output, [MACRO_NUM][MACRO_ROWS][CORE_SIZE]: macro m receives registered window rows (m%GROUPS)*MACRO_ROWS +: MACRO_ROWS.
- m_dout, input, [MACRO_NUM][MACRO_COLS] x signed 4: macro results.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream ready.
- sum_out, output, [MACRO_NUM/GROUPS][MACRO_COLS] x signed OUT_W: accumulated result.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; in_ready is 0 during reset and 1 in IDLE after reset; FSM in IDLE; accumulators, phase counter and cycle counter at 0.
- States: IDLE -> CONV -> SAMPLE -> (CONV of the next phase | DONE) -> IDLE.
- IDLE:
  - in_ready=1.
  - On handshake, register data_in into the window register, clear all accumulators, set phase=0, go to CONV.
- CONV:
  - m_enable=1, m_adc=0, m_chs_ps=phase.
  - Stay EN_CYC cycles, then go to SAMPLE.
- SAMPLE:
  - m_enable=1, m_adc=1.
  - On the last of ADC_CYC cycles, sample m_dout and, for each set s and column c, add sign-extended m_dout[s*GROUPS+g][c] for all g to acc[s][c].
  - If phase==PHASES-1, go to DONE; else phase+1 and go to CONV.
- DONE:
  - m_enable=0, m_adc=0, out_valid=1, sum_out=acc, held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept in DONE.
- Latency: from input handshake to out_valid = PHASES*(EN_CYC+ADC_CYC)+1 cycles.
  - Default: 4*3+1 = 13.
- m_din is driven from the window register only, so it is constant for the whole window. m_chs_ps holds 0 in IDLE.
- Arithmetic: two's-complement sign extension to OUT_W. The default OUT_W is sized so no overflow is possible.
- in_valid is ignored outside IDLE; data_in changes outside IDLE have no effect.
- rst_n low mid-window:
  - Immediate asynchronous return to IDLE with all outputs at reset values.
  - The partial sum is discarded and no out_valid is produced for that window.
- Elaboration error if FM_DEPTH%MACRO_ROWS!=0, MACRO_NUM%GROUPS!=0, or PHASES is outside 1..4.

Optional Feature:
- Macro: MACRO_ARRAY_SEQ_SAT_EN.
- Defined:
  - Parameter SAT_W (default 6, ≤ OUT_W) is active.
  - sum_out is clamped per element to [-2^(SAT_W-1), 2^(SAT_W-1)-1], sign-extended to OUT_W.
  - Output sat_flag (1 bit, reset 0) is valid with out_valid and is 1 if any element was clamped.
- Undefined:
  - No clamping, raw accumulator out.
  - The sat_flag port is absent.

Test Plan:
- Defaults, m_dout model returns +1 on every column each phase, one window -> out_valid 13 cycles after handshake; every sum_out = +8 (2 groups x 4 phases).
- m_dout model returns -8 on macros 0,1 and +7 on macros 2,3 for all phases -> set 0 sums = -64, set 1 sums = +56; no wraparound at OUT_W=7.
- Window with channel k tap 0 = 1 only at k=40 -> m_din[1] and m_din[3] row 8 tap 0 = 1, all other m_din bits 0; m_chs_ps steps 0,1,2,3 with m_adc high exactly 1 cycle per phase.
- out_ready held 0 for 5 cycles in DONE -> out_valid and sum_out stable, in_ready 0, a new in_valid is not accepted; release -> IDLE, next window accepted one cycle later.
- rst_n pulsed low during phase 2 -> all outputs 0 asynchronously; after release, a new window returns a clean sum with no stale accumulation.
- SAT_EN defined, SAT_W=4, all m_dout=+7 -> sum_out = +7 (clamped from 56), sat_flag=1; all m_dout=0 -> sat_flag=0.
